// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard unit and its load-tag queue.
package hazard_pkg;

  // Upper bound on register-index width; narrower indices are zero-extended into tags.
  localparam int unsigned MAX_RA_W = 8;

  localparam logic MODE_SCALAR = 1'b0;
  localparam logic MODE_VECTOR = 1'b1;

  typedef struct packed {
    logic                mode;
    logic [MAX_RA_W-1:0] idx;
  } reg_tag_t;

  typedef enum logic [0:0] {
    StIdle,
    StFlush
  } hazard_fsm_e;

  function automatic reg_tag_t make_tag(input logic mode, input logic [MAX_RA_W-1:0] idx);
    reg_tag_t tag;
    tag.mode = mode;
    tag.idx  = idx;
    return tag;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-side bundle of the hazard unit: EX/MEM/WB operand info, load traffic and controls.
interface hazard_scoreboard_unit_if #(
  parameter int unsigned NREG   = 16,
  parameter int unsigned DATA_W = 144,
  parameter int unsigned NSRC   = 3,
  parameter int unsigned CNT_W  = 32
);
  localparam int unsigned RA_W = $clog2(NREG);

  logic [NSRC-1:0][RA_W-1:0]   ex_src;
  logic [NSRC-1:0]             ex_src_used;
  logic                        ex_mode;
  logic [RA_W-1:0]             mem_rd;
  logic [RA_W-1:0]             wb_rd;
  logic                        mem_we;
  logic                        wb_we;
  logic                        mem_mode;
  logic                        wb_mode;
  logic                        mem_is_load;
  logic [DATA_W-1:0]           mem_alu_result;
  logic [DATA_W-1:0]           wb_result;
  logic                        ld_issue;
  logic                        ld_done;
  logic [DATA_W-1:0]           ld_data;
  logic                        branch_taken;
  logic [NSRC-1:0]             fwd_en;
  logic [NSRC-1:0][DATA_W-1:0] fwd_data;
  logic                        stall;
  logic                        flush_if;
  logic                        flush_id;
  logic                        flush_ex;
  logic                        ldq_full;
  logic [CNT_W-1:0]            stall_cnt;
  logic [CNT_W-1:0]            flush_cnt;

  modport master (
    output ex_src, ex_src_used, ex_mode, mem_rd, wb_rd, mem_we, wb_we, mem_mode, wb_mode,
           mem_is_load, mem_alu_result, wb_result, ld_issue, ld_done, ld_data, branch_taken,
    input  fwd_en, fwd_data, stall, flush_if, flush_id, flush_ex, ldq_full, stall_cnt,
           flush_cnt
  );

  modport slave (
    input  ex_src, ex_src_used, ex_mode, mem_rd, wb_rd, mem_we, wb_we, mem_mode, wb_mode,
           mem_is_load, mem_alu_result, wb_result, ld_issue, ld_done, ld_data, branch_taken,
    output fwd_en, fwd_data, stall, flush_if, flush_id, flush_ex, ldq_full, stall_cnt,
           flush_cnt
  );

endinterface

// File: rtl/hazard_ldq.sv
// In-order FIFO of destination tags for loads outstanding in memory.
module hazard_ldq
  import hazard_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  reg_tag_t push_tag_i,
  input  logic     pop_i,
  output reg_tag_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  reg_tag_t [Depth-1:0] mem_q;
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic                 push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full queue is accepted only when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CntW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_tag_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// EX-stage hazard controller: operand forwarding, load scoreboard with return-cycle bypass,
// branch flush sequencing and saturating stall/flush counters.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned NREG      = 16,
  parameter int unsigned DATA_W    = 144,
  parameter int unsigned NSRC      = 3,
  parameter int unsigned LDQ_DEPTH = 4,
  parameter int unsigned CNT_W     = 32
) (
  input logic                    clk,
  input logic                    rst,
  hazard_scoreboard_unit_if.slave bus
);

  localparam int unsigned RA_W   = $clog2(NREG);
  localparam int unsigned NTAG   = 2 * NREG;
  localparam int unsigned SB_W   = $clog2(NTAG);
  localparam int unsigned PEND_W = $clog2(LDQ_DEPTH + 1);

  // Scalar tags occupy entries [0, NREG), vector tags [NREG, 2*NREG).
  function automatic logic [SB_W-1:0] sb_idx(input reg_tag_t tag);
    logic [SB_W-1:0] idx;
    idx = SB_W'(tag.idx[RA_W-1:0]);
    if (tag.mode) begin
      idx = idx + SB_W'(NREG);
    end
    return idx;
  endfunction

  hazard_fsm_e                 state_q;
  logic [NTAG-1:0][PEND_W-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]            stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]            flush_cnt_q, flush_cnt_d;

  reg_tag_t                    push_tag, head_tag;
  logic                        ldq_full, ldq_empty;
  logic                        push_ok, pop_ok;

  reg_tag_t [NSRC-1:0]         src_tag;
  logic [NSRC-1:0]             mem_hit, wb_hit, byp_hit, pend_hit;
  logic [NSRC-1:0]             fwd_en;
  logic [NSRC-1:0][DATA_W-1:0] fwd_data;
  logic                        hazard, stall;

  assign push_tag = make_tag(bus.mem_mode, MAX_RA_W'(bus.mem_rd));

  hazard_ldq #(
    .Depth(LDQ_DEPTH)
  ) u_ldq (
    .clk_i     (clk),
    .rst_i     (rst),
    .push_i    (bus.ld_issue),
    .push_tag_i(push_tag),
    .pop_i     (bus.ld_done),
    .head_o    (head_tag),
    .full_o    (ldq_full),
    .empty_o   (ldq_empty)
  );

  // Same acceptance rule as the queue, so scoreboard and queue never disagree.
  assign pop_ok  = bus.ld_done && !ldq_empty;
  assign push_ok = bus.ld_issue && (!ldq_full || pop_ok);

  always_comb begin
    pending_d = pending_q;
    if (push_ok) begin
      pending_d[sb_idx(push_tag)] = pending_d[sb_idx(push_tag)] + PEND_W'(1);
    end
    if (pop_ok) begin
      pending_d[sb_idx(head_tag)] = pending_d[sb_idx(head_tag)] - PEND_W'(1);
    end
  end

  always_comb begin
    src_tag  = '0;
    mem_hit  = '0;
    wb_hit   = '0;
    byp_hit  = '0;
    pend_hit = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_tag[i]  = make_tag(bus.ex_mode, MAX_RA_W'(bus.ex_src[i]));
      mem_hit[i]  = bus.ex_src_used[i] && (bus.ex_src[i] == bus.mem_rd) && bus.mem_we &&
                    (bus.ex_mode == bus.mem_mode);
      wb_hit[i]   = bus.ex_src_used[i] && (bus.ex_src[i] == bus.wb_rd) && bus.wb_we &&
                    (bus.ex_mode == bus.wb_mode);
      pend_hit[i] = bus.ex_src_used[i] && (pending_q[sb_idx(src_tag[i])] != '0);
      // Only the last outstanding load to a register may bypass; older ones still leave it stale.
      byp_hit[i]  = bus.ex_src_used[i] && pop_ok && (head_tag == src_tag[i]) &&
                    (pending_q[sb_idx(src_tag[i])] == PEND_W'(1));
    end
  end

  always_comb begin
    fwd_en   = '0;
    fwd_data = '0;
    hazard   = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (byp_hit[i]) begin
        fwd_en[i]   = 1'b1;
        fwd_data[i] = bus.ld_data;
      end else if (mem_hit[i] && !bus.mem_is_load) begin
        fwd_en[i]   = 1'b1;
        fwd_data[i] = bus.mem_alu_result;
      end else if (wb_hit[i]) begin
        fwd_en[i]   = 1'b1;
        fwd_data[i] = bus.wb_result;
      end
      if ((pend_hit[i] && !byp_hit[i]) || (mem_hit[i] && bus.mem_is_load)) begin
        hazard = 1'b1;
      end
    end
    if (bus.mem_is_load && ldq_full && !bus.ld_done) begin
      hazard = 1'b1;
    end
  end

  assign stall = hazard && !bus.branch_taken;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (bus.branch_taken && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Flush leaves the load queue alone: everything in it is older than the branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= bus.branch_taken ? StFlush : StIdle;
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.fwd_en    = fwd_en;
  assign bus.fwd_data  = fwd_data;
  assign bus.stall     = stall;
  assign bus.flush_if  = bus.branch_taken || (state_q == StFlush);
  assign bus.flush_id  = bus.branch_taken;
  assign bus.flush_ex  = bus.branch_taken;
  assign bus.ldq_full  = ldq_full;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench: expected outputs queued per step, compared at the falling edge.
module tb_hazard_scoreboard_unit;
  import hazard_pkg::*;

  localparam int unsigned NREG      = 16;
  localparam int unsigned DATA_W    = 144;
  localparam int unsigned NSRC      = 3;
  localparam int unsigned LDQ_DEPTH = 4;
  localparam int unsigned CNT_W     = 32;

  localparam logic [DATA_W-1:0] VAL_A = {16'hA5A5, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210};
  localparam logic [DATA_W-1:0] VAL_B = {16'h5A5A, 128'h1111_2222_3333_4444_5555_6666_7777_8888};
  localparam logic [DATA_W-1:0] VAL_D = {16'hD00D, 128'hdead_beef_cafe_f00d_0bad_c0de_1234_abcd};
  localparam logic [DATA_W-1:0] ZERO  = '0;

  typedef struct packed {
    logic [NSRC-1:0]             fwd_en;
    logic [NSRC-1:0][DATA_W-1:0] fwd_data;
    logic                        stall;
    logic [2:0]                  flush;
    logic                        ldq_full;
    logic [CNT_W-1:0]            stall_cnt;
    logic [CNT_W-1:0]            flush_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(
    .NREG  (NREG),
    .DATA_W(DATA_W),
    .NSRC  (NSRC),
    .CNT_W (CNT_W)
  ) bus ();

  hazard_scoreboard_unit #(
    .NREG     (NREG),
    .DATA_W   (DATA_W),
    .NSRC     (NSRC),
    .LDQ_DEPTH(LDQ_DEPTH),
    .CNT_W    (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t        exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned m_stall     = 0;
  int unsigned m_flush     = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] want);
    vectors++;
    assert (obs === want)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic clear_inputs();
    bus.ex_src         = '0;
    bus.ex_src_used    = '0;
    bus.ex_mode        = MODE_SCALAR;
    bus.mem_rd         = '0;
    bus.wb_rd          = '0;
    bus.mem_we         = 1'b0;
    bus.wb_we          = 1'b0;
    bus.mem_mode       = MODE_SCALAR;
    bus.wb_mode        = MODE_SCALAR;
    bus.mem_is_load    = 1'b0;
    bus.mem_alu_result = VAL_A;
    bus.wb_result      = VAL_B;
    bus.ld_issue       = 1'b0;
    bus.ld_done        = 1'b0;
    bus.ld_data        = VAL_D;
    bus.branch_taken   = 1'b0;
  endtask

  task automatic set_src(input int i, input int r, input logic used);
    bus.ex_src[i]      = 4'(r);
    bus.ex_src_used[i] = used;
  endtask

  task automatic mem_load(input int r, input logic issue);
    bus.mem_rd      = 4'(r);
    bus.mem_we      = 1'b1;
    bus.mem_mode    = MODE_SCALAR;
    bus.mem_is_load = 1'b1;
    bus.ld_issue    = issue;
  endtask

  task automatic mem_idle();
    bus.mem_we      = 1'b0;
    bus.mem_is_load = 1'b0;
    bus.ld_issue    = 1'b0;
  endtask

  task automatic expect_out(input logic [NSRC-1:0] en, input logic [DATA_W-1:0] d0,
                            input logic [DATA_W-1:0] d1, input logic st, input logic [2:0] fl,
                            input logic full);
    exp_t e;
    e.fwd_en    = en;
    e.fwd_data  = {ZERO, d1, d0};
    e.stall     = st;
    e.flush     = fl;
    e.ldq_full  = full;
    e.stall_cnt = CNT_W'(m_stall);
    e.flush_cnt = CNT_W'(m_flush);
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk("exp_queue_empty", 512'(1), 512'(0));
    end else begin
      e = exp_q.pop_front();
      chk("fwd_en", 512'(bus.fwd_en), 512'(e.fwd_en));
      chk("fwd_data", 512'(bus.fwd_data), 512'(e.fwd_data));
      chk("stall", 512'(bus.stall), 512'(e.stall));
      chk("flush_if_id_ex", 512'({bus.flush_if, bus.flush_id, bus.flush_ex}), 512'(e.flush));
      chk("ldq_full", 512'(bus.ldq_full), 512'(e.ldq_full));
      chk("stall_cnt", 512'(bus.stall_cnt), 512'(e.stall_cnt));
      chk("flush_cnt", 512'(bus.flush_cnt), 512'(e.flush_cnt));
      if (e.stall) m_stall++;
      if (bus.branch_taken) m_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    expect_out(3'b000, ZERO, ZERO, 1'b0, 3'b000, 1'b0);
    cycle();

    // MEM beats WB, then WB alone, then a file mismatch
    set_src(0, 3, 1'b1);
    bus.mem_rd = 4'd3; bus.mem_we = 1'b1;
    bus.wb_rd  = 4'd3; bus.wb_we  = 1'b1;
    expect_out(3'b001, VAL_A, ZERO, 1'b0, 3'b000, 1'b0);
    cycle();
    bus.mem_we = 1'b0;
    expect_out(3'b001, VAL_B, ZERO, 1'b0, 3'b000, 1'b0);
    cycle();
    bus.ex_mode = MODE_VECTOR; bus.mem_we = 1'b1; bus.wb_we = 1'b0;
    expect_out(3'b000, ZERO, ZERO, 1'b0, 3'b000, 1'b0);
    cycle();
    bus.ex_mode = MODE_SCALAR;
    set_src(1, 7, 1'b1);
    set_src(2, 3, 1'b0);
    bus.wb_rd = 4'd7; bus.wb_we = 1'b1;
    expect_out(3'b011, VAL_A, VAL_B, 1'b0, 3'b000, 1'b0);
    cycle();

    // Load-use on r5, data returns three cycles after issue
    clear_inputs();
    set_src(0, 5, 1'b1);
    mem_load(5, 1'b1);
    expect_out(3'b000, ZERO, ZERO, 1'b1, 3'b000, 1'b0);
    cycle();
    mem_idle();
    expect_out(3'b000, ZERO, ZERO, 1'b1, 3'b000, 1'b0);
    cycle();
    expect_out(3'b000, ZERO, ZERO, 1'b1, 3'b000, 1'b0);
    cycle();
    bus.ld_done = 1'b1;
    expect_out(3'b001, VAL_D, ZERO, 1'b0, 3'b000, 1'b0);
    cycle();
    bus.ld_done = 1'b0;
    expect_out(3'b000, ZERO, ZERO, 1'b0, 3'b000, 1'b0);
    cycle();

    // Fill the queue with r8..r11, then a fifth load waits for a return
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      mem_load(8 + k, 1'b1);
      expect_out(3'b000, ZERO, ZERO, 1'b0, 3'b000, 1'b0);
      cycle();
    end
    mem_load(12, 1'b0);
    expect_out(3'b000, ZERO, ZERO, 1'b1, 3'b000, 1'b1);
    cycle();
    bus.ld_done = 1'b1;
    bus.ld_issue = 1'b1;
    expect_out(3'b000, ZERO, ZERO, 1'b0, 3'b000, 1'b1);
    cycle();

    // Drain r9, r10, r11, r12 with consumers in EX
    mem_idle();
    set_src(0, 9, 1'b1);
    expect_out(3'b001, VAL_D, ZERO, 1'b0, 3'b000, 1'b1);
    cycle();
    set_src(0, 11, 1'b1);
    expect_out(3'b000, ZERO, ZERO, 1'b1, 3'b000, 1'b0);
    cycle();
    expect_out(3'b001, VAL_D, ZERO, 1'b0, 3'b000, 1'b0);
    cycle();
    set_src(0, 0, 1'b0);
    expect_out(3'b000, ZERO, ZERO, 1'b0, 3'b000, 1'b0);
    cycle();

    // Return with nothing outstanding must not disturb later tracking
    expect_out(3'b000, ZERO, ZERO, 1'b0, 3'b000, 1'b0);
    cycle();
    bus.ld_done = 1'b0;
    mem_load(2, 1'b1);
    expect_out(3'b000, ZERO, ZERO, 1'b0, 3'b000, 1'b0);
    cycle();
    mem_idle();
    set_src(0, 2, 1'b1);
    expect_out(3'b000, ZERO, ZERO, 1'b1, 3'b000, 1'b0);
    cycle();
    bus.ld_done = 1'b1;
    expect_out(3'b001, VAL_D, ZERO, 1'b0, 3'b000, 1'b0);
    cycle();

    // Branch during a load-use stall, then back-to-back branches
    clear_inputs();
    set_src(0, 6, 1'b1);
    mem_load(6, 1'b1);
    expect_out(3'b000, ZERO, ZERO, 1'b1, 3'b000, 1'b0);
    cycle();
    mem_idle();
    bus.branch_taken = 1'b1;
    expect_out(3'b000, ZERO, ZERO, 1'b0, 3'b111, 1'b0);
    cycle();
    bus.branch_taken = 1'b0;
    set_src(0, 0, 1'b0);
    expect_out(3'b000, ZERO, ZERO, 1'b0, 3'b100, 1'b0);
    cycle();
    bus.branch_taken = 1'b1;
    expect_out(3'b000, ZERO, ZERO, 1'b0, 3'b111, 1'b0);
    cycle();
    expect_out(3'b000, ZERO, ZERO, 1'b0, 3'b111, 1'b0);
    cycle();
    bus.branch_taken = 1'b0;
    expect_out(3'b000, ZERO, ZERO, 1'b0, 3'b100, 1'b0);
    cycle();
    bus.ld_done = 1'b1;
    expect_out(3'b000, ZERO, ZERO, 1'b0, 3'b000, 1'b0);
    cycle();

    // Reset with r13 and r14 outstanding
    clear_inputs();
    mem_load(13, 1'b1);
    expect_out(3'b000, ZERO, ZERO, 1'b0, 3'b000, 1'b0);
    cycle();
    mem_load(14, 1'b1);
    expect_out(3'b000, ZERO, ZERO, 1'b0, 3'b000, 1'b0);
    cycle();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_stall = 0;
    m_flush = 0;
    set_src(0, 13, 1'b1);
    set_src(1, 14, 1'b1);
    expect_out(3'b000, ZERO, ZERO, 1'b0, 3'b000, 1'b0);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
